mem_ctrl: RTL

//  Main-memory endpoint of the MSI snooping bus; sits directly downstream of the bus arbiter.

---
 rtl/msi_pkg.sv | 16 +
 rtl/mem_array.sv | 19 +
 rtl/mem_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/msi_pkg.sv
// msi_pkg: MSI bus command encodings, memory controller FSM states and line helpers
package msi_pkg;
  typedef enum logic [1:0] {
    BUS_RD    = 2'b00,
    BUS_RDX   = 2'b01,
    BUS_UPGR  = 2'b10,
    BUS_FLUSH = 2'b11
  } bus_cmd_e;
  typedef enum logic [2:0] {S_IDLE, S_SNOOP, S_READ, S_RESP, S_WRITE} state_e;
  function automatic int line_off(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return v + 32'(en && ~&v);
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: 1R1W synchronous line RAM with one-cycle read latency, contents not reset
module mem_array #(
  parameter int LINES = 64,
  parameter int WIDTH = 128
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(LINES)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(LINES)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [LINES];
  // write port and registered read port
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: main-memory endpoint of the MSI snooping bus; optional MEM_CTRL_STATS_EN adds event counters
module mem_ctrl
  import msi_pkg::*;
#(
  parameter int NUM_PROCS       = 4,
  parameter int ADDR_SIZE       = 32,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEM_LINES       = 64,
  parameter int MEM_LATENCY     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         bus_valid_i,
  input  logic [1:0]                   bus_cmd_i,
  input  logic [ADDR_SIZE-1:0]         bus_addr_i,
  input  logic [$clog2(NUM_PROCS)-1:0] bus_src_i,
  input  logic [CACHE_LINE_SIZE-1:0]   bus_data_i,
  input  logic                         snoop_flush_i,
  output logic                         mem_ready_o,
  output logic                         mem_data_valid_o,
  output logic [CACHE_LINE_SIZE-1:0]   mem_data_o,
  output logic [$clog2(NUM_PROCS)-1:0] mem_dst_o
`ifdef MEM_CTRL_STATS_EN
  ,
  output logic [31:0]                  stat_rd_o,
  output logic [31:0]                  stat_wb_o,
  output logic [31:0]                  stat_c2c_o
`endif
);
  localparam int OFF = line_off(CACHE_LINE_SIZE);
  localparam int IW = $clog2(MEM_LINES);
  localparam int SW = $clog2(NUM_PROCS);
  localparam int CW = $clog2(MEM_LATENCY + 1);
  // extra READ cycles after the first so the pulse lands at accept + MEM_LATENCY
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LATENCY >= 3 ? MEM_LATENCY - 3 : 0);

  state_e                     state_q, state_d;
  bus_cmd_e                   cmd;
  logic [IW-1:0]              idx_q;
  logic [SW-1:0]              src_q, dst_q;
  logic [CACHE_LINE_SIZE-1:0] wdata_q, data_q, rd_data;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       valid_q, accept, last_rd;
  logic                       unused_addr;

  assign cmd = bus_cmd_e'(bus_cmd_i);
  assign accept = bus_valid_i && state_q == S_IDLE;
  assign last_rd = state_q == S_READ && cnt_q == '0;
  assign unused_addr = ^{bus_addr_i[ADDR_SIZE-1:OFF+IW], bus_addr_i[OFF-1:0]};
  assign mem_ready_o = state_q == S_IDLE;
  assign mem_data_valid_o = valid_q;
  assign mem_data_o = data_q;
  assign mem_dst_o = dst_q;

  mem_array #(.LINES(MEM_LINES), .WIDTH(CACHE_LINE_SIZE)) u_array (
    .clk_i   (clk_i),
    .we_i    (state_q == S_WRITE),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

  // next state and read-latency countdown
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = cmd == BUS_FLUSH ? S_WRITE : cmd == BUS_UPGR ? S_IDLE : S_SNOOP;
      S_SNOOP: begin
        state_d = snoop_flush_i ? S_WRITE : S_READ;
        cnt_d = CNT_LOAD;
      end
      S_READ:  begin
        state_d = last_rd ? S_RESP : S_READ;
        cnt_d = last_rd ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, counter and response registers; the response is captured on the last READ cycle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      dst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      valid_q <= last_rd;
      if (last_rd) begin
        data_q <= rd_data;
        dst_q <= src_q;
      end
    end
  end

  // transaction latch: index and requester at accept, write data at accept or from the snooping cache
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
      src_q <= '0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        idx_q <= bus_addr_i[OFF+IW-1:OFF];
        src_q <= bus_src_i;
      end
      if (accept || state_q == S_SNOOP) wdata_q <= bus_data_i;
    end
  end

`ifdef MEM_CTRL_STATS_EN
  logic [31:0] stat_rd_q, stat_wb_q, stat_c2c_q;
  assign stat_rd_o = stat_rd_q;
  assign stat_wb_o = stat_wb_q;
  assign stat_c2c_o = stat_c2c_q;
  // saturating event counters: responses, Flush writes, snoop aborts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_rd_q <= '0;
      stat_wb_q <= '0;
      stat_c2c_q <= '0;
    end else begin
      stat_rd_q <= sat_inc(stat_rd_q, last_rd);
      stat_wb_q <= sat_inc(stat_wb_q, accept && cmd == BUS_FLUSH);
      stat_c2c_q <= sat_inc(stat_c2c_q, state_q == S_SNOOP && snoop_flush_i);
    end
  end
`endif
endmodule
